// File: rtl/program_sequencer_if.sv
// Fetch-stage bus between the decoder and program_sequencer.
// The decoder side (master) drives op/operands/stall; the sequencer side
// (slave) returns the PC and RAS status. Trap signals exist only when
// PC_TRAP_EN is defined.
interface program_sequencer_if #(
  parameter int ADDR_W    = 24,
  parameter int OFF_W     = 16,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic              stall;
  logic [2:0]        op;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_out;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_full;
  logic              ras_empty;
  logic              stack_err;
`ifdef PC_TRAP_EN
  logic              trap_req;
  logic              trap_ack;
  logic [ADDR_W-1:0] epc;
`endif

`ifdef PC_TRAP_EN
  modport master (
    output stall, op, offset, target, trap_req,
    input  pc_out, ras_count, ras_full, ras_empty, stack_err, trap_ack, epc
  );
  modport slave (
    input  stall, op, offset, target, trap_req,
    output pc_out, ras_count, ras_full, ras_empty, stack_err, trap_ack, epc
  );
`else
  modport master (
    output stall, op, offset, target,
    input  pc_out, ras_count, ras_full, ras_empty, stack_err
  );
  modport slave (
    input  stall, op, offset, target,
    output pc_out, ras_count, ras_full, ras_empty, stack_err
  );
`endif
endinterface

// File: rtl/program_sequencer.sv
// Program counter for the fetch stage: sequential step, PC-relative branch,
// absolute jump, call/return through a circular return-address stack, stall.
// Optional trap entry / exception return is built when PC_TRAP_EN is defined;
// without it op 110 (eret) behaves as inc.
//
// Trap FSM (PC_TRAP_EN only):
//   state      | meaning
//   ST_RUN     | normal execution, a trap_req is taken on the next unstalled edge
//   ST_HANDLER | inside the trap handler, trap_req ignored until eret
module program_sequencer #(
  parameter int                ADDR_W     = 24,
  parameter int                OFF_W      = 16,
  parameter int                RAS_DEPTH  = 8,
  parameter int                STEP       = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
`ifdef PC_TRAP_EN
  ,
  parameter logic [ADDR_W-1:0] TRAP_VEC   = ADDR_W'('h10)
`endif
) (
  input logic                clk,
  input logic                reset,
  program_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_JUMP   = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;
  localparam logic [2:0] OP_ERET   = 3'b110;
  localparam logic [2:0] OP_INC2   = 3'b111;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // tos_q points at the next free slot; the top entry lives at tos_q-1.
  logic [PTR_W-1:0]  tos_q, tos_d;
  logic              err_q, err_d;
  logic              full_q, empty_q;
  logic              push;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] off_ext;
  logic [PTR_W-1:0]  pop_idx;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

`ifdef PC_TRAP_EN
  typedef enum logic {ST_RUN, ST_HANDLER} trap_state_t;
  trap_state_t       state_q, state_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              ack_q, ack_d;
`endif

  assign seq_pc  = pc_q + STEP_A;
  assign off_ext = ADDR_W'($signed(bus.offset));
  assign pop_idx = tos_q - PTR_ONE;

  // Next-state decode: everything holds by default, so stall simply skips the decode.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    tos_d = tos_q;
    err_d = err_q;
    push  = 1'b0;
`ifdef PC_TRAP_EN
    state_d = state_q;
    epc_d   = epc_q;
    ack_d   = 1'b0;
`endif
    if (!bus.stall) begin
`ifdef PC_TRAP_EN
      if (state_q == ST_RUN && bus.trap_req) begin
        epc_d   = pc_q;
        pc_d    = TRAP_VEC;
        state_d = ST_HANDLER;
        ack_d   = 1'b1;
      end else begin
`endif
        case (bus.op)
          OP_HOLD: pc_d = pc_q;
          OP_INC, OP_INC2: pc_d = seq_pc;
          OP_BRANCH: pc_d = pc_q + off_ext;
          OP_JUMP: pc_d = bus.target;
          OP_CALL: begin
            // A full stack wraps over its oldest entry, keeping the newest
            // RAS_DEPTH return addresses poppable.
            push  = 1'b1;
            pc_d  = bus.target;
            tos_d = tos_q + PTR_ONE;
            if (cnt_q == DEPTH_C) err_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_ONE;
          end
          OP_RET: begin
            if (cnt_q == '0) begin
              err_d = 1'b1;
            end else begin
              pc_d  = ras_mem[pop_idx];
              tos_d = pop_idx;
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          OP_ERET: begin
`ifdef PC_TRAP_EN
            pc_d    = epc_q;
            state_d = ST_RUN;
`else
            pc_d    = seq_pc;
`endif
          end
          default: pc_d = pc_q;
        endcase
`ifdef PC_TRAP_EN
      end
`endif
    end
  end

  // Architectural state and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_ADDR;
      cnt_q   <= '0;
      tos_q   <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      tos_q   <= tos_d;
      err_q   <= err_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) ras_mem[tos_q] <= seq_pc;
  end

`ifdef PC_TRAP_EN
  // Trap FSM state, saved exception PC and the single-cycle acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.trap_ack = ack_q;
  assign bus.epc      = epc_q;
`endif

  assign bus.pc_out    = pc_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_full  = full_q;
  assign bus.ras_empty = empty_q;
  assign bus.stack_err = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with default parameters
// (ADDR_W=24, OFF_W=16, RAS_DEPTH=8, STEP=1, RESET_ADDR=0).
module tb_program_sequencer;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_JUMP   = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;
  localparam logic [2:0] OP_ERET   = 3'b110;
  localparam logic [2:0] OP_INC2   = 3'b111;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  program_sequencer_if #(.ADDR_W(24), .OFF_W(16), .RAS_DEPTH(8)) bus ();

  program_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op, clock it in, land 1 time unit after the edge.
  task automatic step(input logic [2:0] o, input logic [23:0] tgt, input logic [15:0] off);
    bus.op     = o;
    bus.target = tgt;
    bus.offset = off;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.op    = OP_HOLD;
    bus.stall = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    bus.stall  = 1'b0;
    bus.op     = OP_HOLD;
    bus.target = '0;
    bus.offset = '0;
`ifdef PC_TRAP_EN
    bus.trap_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", bus.pc_out, 32'h0);
    check_eq("rst_cnt", bus.ras_count, 32'h0);
    check_eq("rst_empty", bus.ras_empty, 32'h1);
    check_eq("rst_full", bus.ras_full, 32'h0);
    check_eq("rst_err", bus.stack_err, 32'h0);
    reset = 1'b1;

    // Sequential increments, including the alternate inc encoding.
    step(OP_INC, 24'h0, 16'h0);
    check_eq("inc1", bus.pc_out, 32'h1);
    step(OP_INC, 24'h0, 16'h0);
    check_eq("inc2", bus.pc_out, 32'h2);
    step(OP_INC2, 24'h0, 16'h0);
    check_eq("inc3", bus.pc_out, 32'h3);
    check_eq("inc_empty", bus.ras_empty, 32'h1);
    step(OP_HOLD, 24'h0, 16'h0);
    check_eq("hold", bus.pc_out, 32'h3);

    // Asynchronous reset mid-cycle with an inc pending.
    bus.op = OP_INC;
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_pc", bus.pc_out, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_held_pc", bus.pc_out, 32'h0);
    reset = 1'b1;
    step(OP_INC, 24'h0, 16'h0);
    check_eq("first_after_rst", bus.pc_out, 32'h1);

    // Branches and wrap-around.
    step(OP_JUMP, 24'h000100, 16'h0);
    check_eq("jump", bus.pc_out, 32'h100);
    step(OP_BRANCH, 24'h0, 16'hFFF0);
    check_eq("br_neg", bus.pc_out, 32'hF0);
    step(OP_BRANCH, 24'h0, 16'h0020);
    check_eq("br_pos", bus.pc_out, 32'h110);
    step(OP_JUMP, 24'hFFFFFF, 16'h0);
    step(OP_BRANCH, 24'h0, 16'h0002);
    check_eq("br_wrap", bus.pc_out, 32'h1);
    step(OP_JUMP, 24'hFFFFFF, 16'h0);
    step(OP_INC, 24'h0, 16'h0);
    check_eq("inc_wrap", bus.pc_out, 32'h0);
    check_eq("wrap_no_err", bus.stack_err, 32'h0);

    // Call / return and underflow.
    step(OP_JUMP, 24'h000010, 16'h0);
    step(OP_CALL, 24'h000200, 16'h0);
    check_eq("call1_pc", bus.pc_out, 32'h200);
    step(OP_CALL, 24'h000300, 16'h0);
    check_eq("call2_pc", bus.pc_out, 32'h300);
    check_eq("call2_cnt", bus.ras_count, 32'h2);
    check_eq("call2_empty", bus.ras_empty, 32'h0);
    step(OP_RET, 24'h0, 16'h0);
    check_eq("ret1_pc", bus.pc_out, 32'h201);
    step(OP_RET, 24'h0, 16'h0);
    check_eq("ret2_pc", bus.pc_out, 32'h11);
    check_eq("ret2_empty", bus.ras_empty, 32'h1);
    check_eq("ret2_err", bus.stack_err, 32'h0);
    step(OP_RET, 24'h0, 16'h0);
    check_eq("under_pc", bus.pc_out, 32'h11);
    check_eq("under_cnt", bus.ras_count, 32'h0);
    check_eq("under_err", bus.stack_err, 32'h1);
    step(OP_INC, 24'h0, 16'h0);
    check_eq("err_sticky", bus.stack_err, 32'h1);

    // Overflow: call i jumps to 0x1000*i and pushes 0x1000*(i-1)+1.
    do_reset();
    check_eq("err_cleared", bus.stack_err, 32'h0);
    for (int i = 1; i <= 8; i++) step(OP_CALL, 24'(32'h1000 * i), 16'h0);
    check_eq("eight_full", bus.ras_full, 32'h1);
    check_eq("eight_err", bus.stack_err, 32'h0);
    step(OP_CALL, 24'h009000, 16'h0);
    check_eq("ovf_cnt", bus.ras_count, 32'h8);
    check_eq("ovf_full", bus.ras_full, 32'h1);
    check_eq("ovf_err", bus.stack_err, 32'h1);
    for (int j = 1; j <= 8; j++) begin
      step(OP_RET, 24'h0, 16'h0);
      check_eq($sformatf("ovf_ret%0d", j), bus.pc_out, 32'h1000 * (9 - j) + 1);
    end
    check_eq("ovf_empty", bus.ras_empty, 32'h1);
    check_eq("ovf_full_clr", bus.ras_full, 32'h0);

    // Stall freezes PC, RAS and flags.
    do_reset();
    step(OP_JUMP, 24'h000050, 16'h0);
    step(OP_CALL, 24'h000400, 16'h0);
    bus.stall = 1'b1;
    step(OP_INC, 24'h0, 16'h0);
    step(OP_INC, 24'h0, 16'h0);
    check_eq("stall_inc_pc", bus.pc_out, 32'h400);
    step(OP_CALL, 24'h000700, 16'h0);
    step(OP_CALL, 24'h000700, 16'h0);
    check_eq("stall_call_pc", bus.pc_out, 32'h400);
    check_eq("stall_cnt", bus.ras_count, 32'h1);
    check_eq("stall_empty", bus.ras_empty, 32'h0);
    bus.stall = 1'b0;
    step(OP_CALL, 24'h000700, 16'h0);
    check_eq("unstall_pc", bus.pc_out, 32'h700);
    check_eq("unstall_cnt", bus.ras_count, 32'h2);
    step(OP_RET, 24'h0, 16'h0);
    check_eq("unstall_ret", bus.pc_out, 32'h401);

`ifdef PC_TRAP_EN
    do_reset();
    check_eq("rst_epc", bus.epc, 32'h0);
    check_eq("rst_ack", bus.trap_ack, 32'h0);
    step(OP_JUMP, 24'h000040, 16'h0);
    bus.trap_req = 1'b1;
    step(OP_INC, 24'h0, 16'h0);
    check_eq("trap_pc", bus.pc_out, 32'h10);
    check_eq("trap_epc", bus.epc, 32'h40);
    check_eq("trap_ack", bus.trap_ack, 32'h1);
    step(OP_INC, 24'h0, 16'h0);
    check_eq("trap2_pc", bus.pc_out, 32'h11);
    check_eq("trap2_ack", bus.trap_ack, 32'h0);
    check_eq("trap2_epc", bus.epc, 32'h40);
    bus.trap_req = 1'b0;
    step(OP_ERET, 24'h0, 16'h0);
    check_eq("eret_pc", bus.pc_out, 32'h40);
`else
    do_reset();
    step(OP_JUMP, 24'h000040, 16'h0);
    step(OP_ERET, 24'h0, 16'h0);
    check_eq("eret_as_inc", bus.pc_out, 32'h41);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
